// File: rtl/segre_dcache_ctrl.sv
// Blocking, direct-mapped, write-back/write-allocate data cache controller.
// Handles core-side lookup and store merge, and fills or evicts whole lines
// through a hold-until-ready memory handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | lookup; hits serviced in the same cycle, a miss leaves IDLE
// S_WB      | dirty victim line being written back to memory
// S_REFILL  | missed line being read from memory and installed
module segre_dcache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BYTES = 16,
   parameter int NUM_LINES  = 4
) (
   input  logic                      clk_i,
   input  logic                      rsn_i,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [3:0]                be_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [31:0]               wdata_i,
   output logic [31:0]               rdata_o,
   output logic                      hit_o,
   output logic                      busy_o,
   output logic                      mem_rd_o,
   output logic                      mem_wr_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [8*LINE_BYTES-1:0]   mem_wdata_o,
   input  logic [8*LINE_BYTES-1:0]   mem_rdata_i,
   input  logic                      mem_ready_i
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int WORDS  = LINE_BYTES / 4;
   localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WB     = 2'd1,
      S_REFILL = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_arr_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_arr_q [NUM_LINES];

   logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
   logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;

   logic [TAG_W-1:0]     req_tag;
   logic [IDX_W-1:0]     req_idx;
   logic [OFF_W-1:0]     req_off;
   logic                 req_v;
   logic                 lookup_hit;
   logic                 miss;
   logic                 store_hit;
   logic                 wb_done;
   logic                 refill_done;
   logic [LINE_W-1:0]    store_line;
   logic [31:0]          rd_word;

   // A core request held across reset must not show up as busy.
   assign req_v   = req_i & rsn_i;
   assign req_tag = addr_i[ADDR_WIDTH-1:OFF_W+IDX_W];
   assign req_idx = addr_i[OFF_W+IDX_W-1:OFF_W];
   assign req_off = addr_i[OFF_W-1:0] & WORD_MASK;

   assign lookup_hit  = req_v & valid_q[req_idx] & (tag_arr_q[req_idx] == req_tag);
   assign miss        = (state_q == S_IDLE) & req_v & ~lookup_hit;
   assign store_hit   = (state_q == S_IDLE) & lookup_hit & we_i;
   assign wb_done     = (state_q == S_WB) & mem_ready_i;
   assign refill_done = (state_q == S_REFILL) & mem_ready_i;

   // Word select for loads and byte-enable merge for stores on the indexed line.
   always_comb begin
      store_line = data_arr_q[req_idx];
      rd_word    = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (req_off == OFF_W'(4 * k)) begin
            rd_word = data_arr_q[req_idx][32*k +: 32];
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) store_line[32*k + 8*b +: 8] = wdata_i[8*b +: 8];
            end
         end
      end
   end

   // State register and latched miss address.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q    <= S_IDLE;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         miss_tag_q <= miss_tag_d;
         miss_idx_q <= miss_idx_d;
      end
   end

   // Next-state logic; the miss address is captured only on leaving IDLE.
   always_comb begin
      state_d    = state_q;
      miss_tag_d = miss_tag_q;
      miss_idx_d = miss_idx_q;
      case (state_q)
         S_IDLE: begin
            if (miss) begin
               miss_tag_d = req_tag;
               miss_idx_d = req_idx;
               state_d    = (valid_q[req_idx] & dirty_q[req_idx]) ? S_WB : S_REFILL;
            end
         end
         S_WB:     if (mem_ready_i) state_d = S_REFILL;
         S_REFILL: if (mem_ready_i) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Core-side and memory-side outputs decoded from the current state.
   always_comb begin
      hit_o       = 1'b0;
      busy_o      = 1'b0;
      rdata_o     = '0;
      mem_rd_o    = 1'b0;
      mem_wr_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         S_IDLE: begin
            hit_o   = lookup_hit;
            busy_o  = req_v & ~lookup_hit;
            rdata_o = rd_word;
         end
         S_WB: begin
            busy_o      = 1'b1;
            mem_wr_o    = 1'b1;
            mem_addr_o  = {tag_arr_q[miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
            mem_wdata_o = data_arr_q[miss_idx_q];
         end
         S_REFILL: begin
            busy_o     = 1'b1;
            mem_rd_o   = 1'b1;
            mem_addr_o = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
         end
         default: ;
      endcase
   end

   // Line storage: store-hit merge, writeback clean, refill install.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            tag_arr_q[i]  <= '0;
            data_arr_q[i] <= '0;
         end
      end else begin
         if (store_hit) begin
            data_arr_q[req_idx] <= store_line;
            dirty_q[req_idx]    <= 1'b1;
         end
         if (wb_done) dirty_q[miss_idx_q] <= 1'b0;
         if (refill_done) begin
            data_arr_q[miss_idx_q] <= mem_rdata_i;
            tag_arr_q[miss_idx_q]  <= miss_tag_q;
            valid_q[miss_idx_q]    <= 1'b1;
            dirty_q[miss_idx_q]    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_segre_dcache_ctrl.sv
// Bench for segre_dcache_ctrl: directed scenarios followed by random accesses,
// checked against a line-level cache and main-memory model.
module tb_segre_dcache_ctrl;

   logic          clk_i = 1'b0;
   logic          rsn_i;
   logic          req_i;
   logic          we_i;
   logic [3:0]    be_i;
   logic [31:0]   addr_i;
   logic [31:0]   wdata_i;
   logic [31:0]   rdata_o;
   logic          hit_o;
   logic          busy_o;
   logic          mem_rd_o;
   logic          mem_wr_o;
   logic [31:0]   mem_addr_o;
   logic [127:0]  mem_wdata_o;
   logic [127:0]  mem_rdata_i;
   logic          mem_ready_i;

   segre_dcache_ctrl dut (
      .clk_i       (clk_i),
      .rsn_i       (rsn_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .be_i        (be_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_o     (rdata_o),
      .hit_o       (hit_o),
      .busy_o      (busy_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Reference model: cache lines and a sparse main memory of whole lines.
   bit           m_valid [4];
   bit           m_dirty [4];
   logic [25:0]  m_tag   [4];
   logic [127:0] m_data  [4];
   logic [127:0] mem_m   [int unsigned];

   logic [31:0]  last_rdata;
   logic [127:0] last_wb_data;
   int           wb_cycles;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] get_line(input logic [31:0] a);
      if (!mem_m.exists(a)) mem_m[a] = {$urandom, $urandom, $urandom, $urandom};
      return mem_m[a];
   endfunction

   // One core access held until it completes, playing the memory side with
   // the given wait-state counts; all expectations come from the model.
   task automatic access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input int wwb, input int wrf, input bit noise);
      logic [1:0]   idx;
      logic [25:0]  tag;
      int           word;
      bit           exp_hit;
      bit           vdirty;
      logic [31:0]  vaddr;
      logic [31:0]  laddr;
      logic [127:0] rline;
      idx     = addr[5:4];
      tag     = addr[31:6];
      word    = int'(addr[3:2]);
      exp_hit = m_valid[idx] && (m_tag[idx] == tag);
      vdirty  = m_valid[idx] && m_dirty[idx];
      vaddr   = {m_tag[idx], idx, 4'b0000};
      laddr   = {addr[31:4], 4'b0000};
      wb_cycles = 0;
      req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
      mem_ready_i = exp_hit ? noise : 1'b0;
      @(negedge clk_i);
      check("first_hit", hit_o, exp_hit);
      check("first_busy", busy_o, !exp_hit);
      if (!exp_hit) begin
         @(posedge clk_i); #1;
         if (vdirty) begin
            for (int w = 0; w <= wwb; w++) begin
               mem_ready_i = (w == wwb);
               @(negedge clk_i);
               wb_cycles++;
               last_wb_data = mem_wdata_o;
               check("wb_wr", mem_wr_o, 1'b1);
               check("wb_rd", mem_rd_o, 1'b0);
               check("wb_addr", mem_addr_o, vaddr);
               check("wb_data", mem_wdata_o, m_data[idx]);
               check("wb_busy", busy_o, 1'b1);
               check("wb_hit", hit_o, 1'b0);
               @(posedge clk_i); #1;
            end
            mem_ready_i = 1'b0;
            mem_m[vaddr] = m_data[idx];
            m_dirty[idx] = 1'b0;
         end
         rline = get_line(laddr);
         mem_rdata_i = rline;
         for (int w = 0; w <= wrf; w++) begin
            mem_ready_i = (w == wrf);
            @(negedge clk_i);
            check("rf_rd", mem_rd_o, 1'b1);
            check("rf_wr", mem_wr_o, 1'b0);
            check("rf_addr", mem_addr_o, laddr);
            check("rf_busy", busy_o, 1'b1);
            check("rf_hit", hit_o, 1'b0);
            @(posedge clk_i); #1;
         end
         mem_ready_i = 1'b0;
         mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
         m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tag; m_data[idx] = rline;
         @(negedge clk_i);
         check("replay_hit", hit_o, 1'b1);
         check("replay_busy", busy_o, 1'b0);
      end
      check("hit_no_rd", mem_rd_o, 1'b0);
      check("hit_no_wr", mem_wr_o, 1'b0);
      last_rdata = rdata_o;
      if (!we) begin
         check("load_data", rdata_o, m_data[idx][32*word +: 32]);
      end else begin
         for (int b = 0; b < 4; b++)
            if (be[b]) m_data[idx][32*word + 8*b +: 8] = wd[8*b +: 8];
         m_dirty[idx] = 1'b1;
      end
      @(posedge clk_i); #1;
      req_i = 1'b0;
      mem_ready_i = 1'b0;
   endtask

   initial begin
      logic [127:0] rline;
      rsn_i = 1'b0; req_i = 1'b1; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0;
      wdata_i = 32'h0; mem_rdata_i = '0; mem_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
      mem_m[32'h100] = 128'h44444444_33333333_22222222_11111111;

      // Outputs under reset, with a request already presented.
      #2;
      check("rst_hit", hit_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_rd", mem_rd_o, 1'b0);
      check("rst_wr", mem_wr_o, 1'b0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_wdata", mem_wdata_o, 128'h0);
      check("rst_rdata", rdata_o, 32'h0);
      @(posedge clk_i); #1;
      rsn_i = 1'b1; req_i = 1'b0;
      @(posedge clk_i); #1;

      // Cold load, 3 wait cycles.
      access(1'b0, 4'h0, 32'h104, 32'h0, 0, 3, 1'b0);
      check("tp_cold_rdata", last_rdata, 32'h22222222);
      // Store hit then reload.
      access(1'b1, 4'b0011, 32'h104, 32'hAAAABBBB, 0, 0, 1'b0);
      access(1'b0, 4'h0, 32'h104, 32'h0, 0, 0, 1'b0);
      check("tp_merge_rdata", last_rdata, 32'h2222BBBB);
      // Dirty conflict: writeback then refill.
      access(1'b0, 4'h0, 32'h144, 32'h0, 1, 0, 1'b0);
      check("tp_wb_word1", last_wb_data[63:32], 32'h2222BBBB);
      check("tp_wb_count", wb_cycles, 2);
      // Clean conflict: no writeback.
      access(1'b0, 4'h0, 32'h184, 32'h0, 0, 1, 1'b0);
      check("tp_clean_nowb", wb_cycles, 0);

      // Reset in the middle of a refill.
      access(1'b0, 4'h0, 32'h104, 32'h0, 0, 0, 1'b0);
      access(1'b0, 4'h0, 32'h118, 32'h0, 0, 0, 1'b0);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h200;
      @(negedge clk_i);
      check("rstmid_miss_busy", busy_o, 1'b1);
      @(posedge clk_i); #1;
      check("rstmid_rd_before", mem_rd_o, 1'b1);
      #1 rsn_i = 1'b0;
      #1;
      check("rstmid_rd_drop", mem_rd_o, 1'b0);
      check("rstmid_busy_drop", busy_o, 1'b0);
      check("rstmid_addr", mem_addr_o, 32'h0);
      @(posedge clk_i); #1;
      rsn_i = 1'b1; req_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
      end
      access(1'b0, 4'h0, 32'h200, 32'h0, 0, 0, 1'b0);
      access(1'b0, 4'h0, 32'h104, 32'h0, 0, 2, 1'b0);
      check("rst_refetch_0x104", last_rdata, 32'h2222BBBB);

      // Request withdrawn during a slow refill; line still installed.
      rline = get_line(32'h3A0);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h3A8;
      @(negedge clk_i);
      check("drop_miss_busy", busy_o, 1'b1);
      @(posedge clk_i); #1;
      req_i = 1'b0;
      mem_rdata_i = rline;
      for (int w = 0; w <= 5; w++) begin
         mem_ready_i = (w == 5);
         @(negedge clk_i);
         check("drop_rd", mem_rd_o, 1'b1);
         check("drop_busy", busy_o, 1'b1);
         @(posedge clk_i); #1;
      end
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      @(negedge clk_i);
      check("drop_rd_low", mem_rd_o, 1'b0);
      check("drop_idle_busy", busy_o, 1'b0);
      check("drop_idle_hit", hit_o, 1'b0);
      m_valid[2] = 1'b1; m_dirty[2] = 1'b0; m_tag[2] = 26'hE; m_data[2] = rline;
      @(posedge clk_i); #1;
      access(1'b0, 4'h0, 32'h3A8, 32'h0, 0, 0, 1'b0);
      check("drop_later_data", last_rdata, rline[95:64]);

      // Random traffic over a small address window to force conflicts.
      for (int n = 0; n < 120; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 63) << 4) | ($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 3) == 0) begin
            req_i = 1'b0;
            mem_ready_i = 1'($urandom);
            @(negedge clk_i);
            check("idle_busy", busy_o, 1'b0);
            check("idle_rd", mem_rd_o, 1'b0);
            check("idle_wr", mem_wr_o, 1'b0);
            @(posedge clk_i); #1;
            mem_ready_i = 1'b0;
         end
         access(1'($urandom), 4'($urandom_range(0, 15)), a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/segre_dcache_ctrl.md
Name: segre_dcache_ctrl

Overview:
- Blocking, direct-mapped, write-back, write-allocate data cache with its miss-handling FSM, serving the core's MEM stage.
- Core side produces the hit and busy indications that the core controller samples in MEM_STATE: MEM_STATE holds while busy, or while not hit on a memory instruction.
- Memory side issues whole-line writebacks and refills to main memory with a hold-until-ready handshake.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_BYTES, 16, bytes per line; power of two, >= 4
NUM_LINES, 4, lines in cache; power of two
Derived: OFF_W=log2(LINE_BYTES)=4, IDX_W=log2(NUM_LINES)=2, TAG_W=ADDR_WIDTH-OFF_W-IDX_W=26, LINE_W=8*LINE_BYTES=128

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  reset, asynchronous, active-low
req_i  in  1  core access valid (high in MEM_STATE for a memory instruction)
we_i  in  1  1=store, 0=load
be_i  in  4  store byte enables within the addressed word
addr_i  in  ADDR_WIDTH  byte address; addr_i[1:0] ignored
wdata_i  in  32  store data
rdata_o  out  32  load data, addressed word of hit line
hit_o  out  1  access hits this cycle
busy_o  out  1  miss handling in progress
mem_rd_o  out  1  line read request
mem_wr_o  out  1  line write request
mem_addr_o  out  ADDR_WIDTH  line-aligned address (low OFF_W bits zero)
mem_wdata_o  out  LINE_W  victim line data
mem_rdata_i  in  LINE_W  refill data, valid when mem_ready_i high during read
mem_ready_i  in  1  one-cycle completion pulse for the current request

Behaviour:
- Address split: tag=addr[ADDR_WIDTH-1:OFF_W+IDX_W], idx=addr[OFF_W+IDX_W-1:OFF_W], word=addr[OFF_W-1:2].
- Storage per line: valid, dirty, tag, LINE_W data.
- Reset (async, rsn_i low):
  - state=IDLE; all valid and dirty bits cleared; data and tag contents don't-care.
  - Outputs: hit_o=0, busy_o=0, mem_rd_o=0, mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0.
  - Reset mid-WRITEBACK or mid-REFILL aborts immediately; the line is not installed.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE:
  - hit_o=req_i & valid[idx] & tag match, combinational, same cycle.
  - rdata_o=selected word of line[idx] (combinational, every cycle in IDLE).
  - Store hit: at the clock edge, bytes with be_i=1 are written into the word and dirty[idx]=1.
  - Load hit: no state change.
  - Miss (req_i & !hit): victim valid & dirty -> WRITEBACK; otherwise -> REFILL.
  - The miss address (tag, idx) is latched at the transition; later addr_i changes are ignored until IDLE.
- busy_o=1 in WRITEBACK and REFILL, and also in the miss cycle itself (combinational: IDLE & req_i & !hit).
- hit_o=0 whenever state != IDLE.
- WRITEBACK:
  - Outputs: mem_wr_o=1, mem_addr_o={victim tag, idx, 0}, mem_wdata_o=victim line, all stable.
  - On mem_ready_i: dirty[idx]=0 and state -> REFILL.
  - mem_wr_o low in the next cycle.
- REFILL:
  - Outputs: mem_rd_o=1, mem_addr_o={miss tag, idx, 0}.
  - On mem_ready_i: line[idx]=mem_rdata_i, tag updated, valid=1, dirty=0, state -> IDLE.
  - mem_rd_o low in the next cycle.
- Replay: the core keeps req_i high; the access re-evaluates in IDLE the cycle after refill and hits. A store then merges and sets dirty.
- Minimum miss latency:
  - clean miss, 0-wait memory: miss cycle + 1 REFILL cycle, hit in the 3rd cycle;
  - dirty miss: one additional WRITEBACK cycle per transaction.
- mem_rd_o and mem_wr_o are never high together; each is held until mem_ready_i.
- mem_ready_i is ignored in IDLE.
- req_i dropped during miss handling: the transaction still completes and installs the line; no core-side effect.
- mem_rdata_i byte n maps to address line_base+n (little-endian). Word k of the line is bits [32k+31:32k].

Test Plan:
- Cold load, addr 0x0000_0104: busy_o=1, hit_o=0; mem_rd_o, mem_addr_o=0x100; memory returns line 0x44444444_33333333_22222222_11111111 after 3 wait cycles, then mem_rd_o drops. Next cycle hit_o=1, rdata_o=0x22222222.
- Store hit 0x104, be_i=4'b0011, wdata_i=0xAAAABBBB: hit_o=1 same cycle, no memory traffic. Following load of 0x104 returns 0x2222BBBB.
- Conflict load 0x0000_0144 (same idx 0, dirty): mem_wr_o with mem_addr_o=0x100 and word1=0x2222BBBB, then mem_rd_o with mem_addr_o=0x140. Then hit_o=1 and dirty[0]=0.
- Clean conflict eviction: load 0x184 after a clean 0x144 fill -> REFILL only, mem_wr_o never asserted.
- rsn_i low during REFILL of 0x200: mem_rd_o and busy_o drop asynchronously. After release, load 0x200 misses again and a prior-valid 0x104 also misses.
- req_i deasserted mid-REFILL with mem_ready_i delayed 5 cycles: line installed; a later req_i to that address hits with zero busy cycles.
